// File: rtl/ins_ram_loader.sv
// ins_ram_loader: boot-time instruction RAM writer.
// Accepts a byte stream (16-bit big-endian word count, then big-endian
// 32-bit words) and writes each word to word-aligned RAM addresses while
// holding the CPU in reset.
// Optional build macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module ins_ram_loader #(
  parameter int          DEPTH         = 4096,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter bit          HOLD_AT_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        we,
  output logic [31:0] wa,
  output logic [31:0] wd,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT_HI = 3'd1,
    S_CNT_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
`ifdef LOADER_CHECKSUM_EN
    S_CHK    = 3'd6,
`endif
    S_DONE   = 3'd5
  } state_t;

  // State entered once the last word is written (or the count is zero).
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CHK;
`else
  localparam state_t S_END = S_DONE;
`endif

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic        in_ready_q, in_ready_d;
  logic        we_q, we_d;
  logic [31:0] wa_q, wa_d;
  logic [31:0] wd_q, wd_d;
  logic        hold_q, hold_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  xor_q, xor_d;
`endif
  logic        accept_s;
  logic [15:0] n_s;

  assign accept_s = in_valid && in_ready_q;
  assign n_s      = {cnt_q[15:8], in_data};

  // Next-state and next-output computation for the load sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    we_d       = 1'b0;
    wa_d       = wa_q;
    wd_d       = wd_q;
    hold_d     = hold_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
`ifdef LOADER_CHECKSUM_EN
    xor_d      = xor_q;
    if (accept_s && (state_q != S_CHK)) begin
      xor_d = xor_q ^ in_data;
    end else begin
      xor_d = xor_q;
    end
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_CNT_HI;
          done_d     = 1'b0;
          error_d    = 1'b0;
          idx_d      = 16'd0;
          cnt_d      = 16'd0;
          byte_cnt_d = 2'd0;
          busy_d     = 1'b1;
          hold_d     = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          xor_d      = 8'h00;
`endif
        end else begin
          state_d = state_q;
        end
      end
      S_CNT_HI: begin
        if (accept_s) begin
          cnt_d   = {in_data, 8'h00};
          state_d = S_CNT_LO;
        end else begin
          state_d = S_CNT_HI;
        end
      end
      S_CNT_LO: begin
        if (accept_s) begin
          cnt_d = n_s;
          if (n_s == 16'd0) begin
            state_d = S_END;
          end else if ({16'd0, n_s} > DEPTH_W) begin
            // Oversized image: reject without any write or checksum byte.
            error_d = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_CNT_LO;
        end
      end
      S_DATA: begin
        if (accept_s) begin
          shift_d    = {shift_q[15:0], in_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = S_WRITE;
            we_d    = 1'b1;
            wd_d    = {shift_q, in_data};
            wa_d    = BASE_ADDR + {14'd0, idx_q, 2'b00};
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_WRITE: begin
        idx_d = idx_q + 16'd1;
        if ((idx_q + 16'd1) == cnt_q) begin
          state_d = S_END;
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept_s) begin
          if (in_data != xor_q) begin
            error_d = 1'b1;
          end else begin
            error_d = error_q;
          end
          state_d = S_DONE;
        end else begin
          state_d = S_CHK;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Completion releases the CPU whether or not the load succeeded.
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      busy_d = 1'b0;
      done_d = 1'b1;
      hold_d = 1'b0;
    end else begin
      busy_d = busy_d;
    end

    in_ready_d = (state_d == S_CNT_HI) || (state_d == S_CNT_LO) ||
`ifdef LOADER_CHECKSUM_EN
                 (state_d == S_CHK) ||
`endif
                 (state_d == S_DATA);
  end

  // State and registered-output flops with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 16'd0;
      idx_q      <= 16'd0;
      byte_cnt_q <= 2'd0;
      shift_q    <= 24'd0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      wa_q       <= BASE_ADDR;
      wd_q       <= 32'd0;
      hold_q     <= HOLD_AT_RESET;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

  assign in_ready = in_ready_q;
  assign we       = we_q;
  assign wa       = wa_q;
  assign wd       = wd_q;
  assign cpu_hold = hold_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_ins_ram_loader.sv
// Self-checking bench for ins_ram_loader: table vectors, hand sequences
// for reset/abort and start-while-busy, and randomized loads against a
// stream-level reference model.
module tb_ins_ram_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, we, cpu_hold, busy, done, error;
  logic [31:0] wa, wd;

  int checks = 0;
  int errors = 0;

  logic [7:0]  stim_q[$];
  logic [63:0] cap_q[$];

  ins_ram_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .we(we), .wa(wa), .wd(wd),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Capture every write pulse; the loader must not accept bytes while writing.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      cap_q.push_back({wa, wd});
      check("in_ready_low_in_write", 32'(in_ready), 32'd0);
    end
  end

  // Reference model: expected results derived directly from the stream.
  task automatic check_load(input string tag, input bit bad);
    int n; bit ovf; int nw; logic [31:0] w; bit exp_err;
    n = int'({stim_q[0], stim_q[1]});
    ovf = n > 4096;
    nw = ovf ? 0 : n;
    exp_err = ovf;
`ifdef LOADER_CHECKSUM_EN
    if (!ovf && bad) exp_err = 1'b1;
`endif
    check({tag, " nwrites"}, 32'(cap_q.size()), 32'(nw));
    for (int i = 0; i < nw && i < cap_q.size(); i++) begin
      w = {stim_q[2+4*i], stim_q[3+4*i], stim_q[4+4*i], stim_q[5+4*i]};
      check($sformatf("%s wa%0d", tag, i), cap_q[i][63:32], 32'(4*i));
      check($sformatf("%s wd%0d", tag, i), cap_q[i][31:0], w);
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " cpu_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, " error"}, 32'(error), 32'(exp_err));
  endtask

  // Start a load and feed the stream; mode 0=always valid, 1=toggle, 2=random.
  task automatic run_load(input string tag, input int mode, input bit poke, input bit bad);
    logic [7:0] s[$]; int n; bit ovf; logic [7:0] x; int idx; int cyc; bit acc;
    s = stim_q;
    n = int'({s[0], s[1]});
    ovf = n > 4096;
    x = 8'h00;
`ifdef LOADER_CHECKSUM_EN
    if (!ovf) begin
      foreach (s[i]) x = x ^ s[i];
      if (bad) x = x ^ 8'h01;
      s.push_back(x);
    end
`endif
    cap_q.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = poke;
    idx = 0; cyc = 0;
    while (idx < s.size() && cyc < 2000) begin
      if (mode == 0) in_valid = 1'b1;
      else if (mode == 1) in_valid = (cyc % 2 == 0);
      else in_valid = 1'($urandom_range(0, 1));
      in_data = s[idx];
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    check({tag, " bytes_fed"}, 32'(idx), 32'(s.size()));
    cyc = 0;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_load(tag, bad);
  endtask

  typedef struct {
    logic [79:0] bytes;   // first stream byte in the MSB
    int          len;
    int          mode;
    bit          poke;
    int          exp_nw;
    bit          exp_err;
    logic [31:0] exp_w0;
    logic [31:0] exp_w1;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [31:0] rw;
    int n;

    vecs[0] = '{80'h0002_2001_0003_2002_0002, 10, 0, 1'b0, 2, 1'b0, 32'h2001_0003, 32'h2002_0002};
    vecs[1] = '{80'h0002_2001_0003_2002_0002, 10, 1, 1'b0, 2, 1'b0, 32'h2001_0003, 32'h2002_0002};
    vecs[2] = '{80'h1001_0000_0000_0000_0000,  2, 0, 1'b0, 0, 1'b1, 32'h0, 32'h0};
    vecs[3] = '{80'h0000_0000_0000_0000_0000,  2, 0, 1'b0, 0, 1'b0, 32'h0, 32'h0};
    vecs[4] = '{80'h0002_DEAD_BEEF_0123_4567, 10, 0, 1'b1, 2, 1'b0, 32'hDEAD_BEEF, 32'h0123_4567};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst we", 32'(we), 32'd0);
    check("rst wa", wa, 32'h0);
    check("rst wd", wd, 32'h0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst error", 32'(error), 32'd0);
    check("rst cpu_hold", 32'(cpu_hold), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table vectors
    for (int v = 0; v < 5; v++) begin
      stim_q.delete();
      for (int b = 0; b < vecs[v].len; b++) stim_q.push_back(vecs[v].bytes[79-8*b -: 8]);
      run_load($sformatf("vec%0d", v), vecs[v].mode, vecs[v].poke, 1'b0);
      check($sformatf("vec%0d tbl_nw", v), 32'(cap_q.size()), 32'(vecs[v].exp_nw));
      check($sformatf("vec%0d tbl_err", v), 32'(error), 32'(vecs[v].exp_err));
      if (vecs[v].exp_nw > 0 && cap_q.size() > 0)
        check($sformatf("vec%0d tbl_w0", v), cap_q[0][31:0], vecs[v].exp_w0);
      if (vecs[v].exp_nw > 1 && cap_q.size() > 1)
        check($sformatf("vec%0d tbl_w1", v), cap_q[1][31:0], vecs[v].exp_w1);
      if (v == 2) begin
        // A new start after the oversize error clears error and done.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("restart error_cleared", 32'(error), 32'd0);
        check("restart done_cleared", 32'(done), 32'd0);
        check("restart busy", 32'(busy), 32'd1);
        check("restart cpu_hold", 32'(cpu_hold), 32'd1);
        rst = 1'b1; #2; rst = 1'b0;
        @(posedge clk); #1;
      end
    end

    // Reset in the middle of the first word's 3rd byte
    stim_q = '{8'h00, 8'h02, 8'h11, 8'h22};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < 4; b++) begin
      in_valid = 1'b1; in_data = stim_q[b];
      @(posedge clk); #1;
    end
    in_data = 8'h33;
    #2 rst = 1'b1;
    #1;
    check("abort in_ready", 32'(in_ready), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort cpu_hold", 32'(cpu_hold), 32'd1);
    check("abort wa", wa, 32'h0);
    check("abort wd", wd, 32'h0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    stim_q = '{8'h00, 8'h01, 8'hC0, 8'hFF, 8'hEE, 8'h01};
    run_load("after_abort", 0, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    stim_q = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load("chk_good", 0, 1'b0, 1'b0);
    run_load("chk_bad", 0, 1'b0, 1'b1);
`endif

    // Randomized loads against the model
    for (int r = 0; r < 10; r++) begin
      stim_q.delete();
      n = (r == 7) ? int'($urandom_range(4097, 65535)) : int'($urandom_range(1, 6));
      stim_q.push_back(8'(n >> 8));
      stim_q.push_back(8'(n));
      if (n <= 4096) begin
        for (int w = 0; w < n; w++) begin
          rw = $urandom;
          for (int b = 3; b >= 0; b--) stim_q.push_back(rw[8*b +: 8]);
        end
      end
      run_load($sformatf("rand%0d", r), 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
